axi_lite_master: RTL
====================

// Module: axi_lite_master
// PURPOSE
//  Single-outstanding AXI4-Lite initiator driving the AR/R and AW/W/B channels from a simple command port.
//  Converts one command (read or write) into a fully compliant AXI handshake sequence and returns one response.
//  Sits upstream of the slave under test; provides the stimulus traffic that the channel spy blocks observe.
// PARAMETERS
//  ADDR_WIDTH  32  width of cmd_addr / ARADDR / AWADDR
//  DATA_WIDTH  32  width of cmd_wdata / WDATA / RDATA / rsp_rdata; multiple of 8
// PORTS
//  clk         in   1             rising-edge clock
//  reset       in   1             synchronous, active-high reset
//  cmd_valid   in   1             command request
//  cmd_ready   out  1             command accepted when cmd_valid & cmd_ready
//  cmd_write   in   1             1 = write, 0 = read
//  cmd_addr    in   ADDR_WIDTH    transaction address
//  cmd_wdata   in   DATA_WIDTH    write data (ignored for reads)
//  rsp_valid   out  1             response available
//  rsp_ready   in   1             response consumed when rsp_valid & rsp_ready
//  rsp_write   out  1             response belongs to a write
//  rsp_rdata   out  DATA_WIDTH    read data (0 for writes)
//  rsp_resp    out  2             RRESP/BRESP captured from slave
//  ARVALID/ARREADY out/in 1; ARADDR out ADDR_WIDTH
//  RVALID/RREADY   in/out 1; RDATA in DATA_WIDTH; RRESP in 2
//  AWVALID/AWREADY out/in 1; AWADDR out ADDR_WIDTH
//  WVALID/WREADY   out/in 1; WDATA out DATA_WIDTH; WSTRB out DATA_WIDTH/8 (all ones)
//  BVALID/BREADY   in/out 1; BRESP in 2
// BEHAVIOUR
//  Reset: all VALID/READY outputs 0, cmd_ready 0, rsp_valid 0, rsp_* 0, ARADDR/AWADDR/WDATA 0, state IDLE.
//  FSM states: IDLE, RD_ADDR, RD_DATA, WR_REQ, WR_RESP, RSP.
//  IDLE: cmd_ready=1. Accept -> latch addr/data/write; next cycle RD_ADDR (ARVALID=1) or WR_REQ (AWVALID=WVALID=1).
//   Latency: command accept at cycle N -> ARVALID/AWVALID high at N+1.
//  RD_ADDR: hold ARVALID, ARADDR stable until ARREADY; on handshake ARVALID=0, RREADY=1 next cycle -> RD_DATA.
//  RD_DATA: RREADY=1; on RVALID capture RDATA/RRESP, RREADY=0 next cycle -> RSP.
//  WR_REQ: AW and W independent; each VALID drops the cycle after its own handshake; both may complete in the same
//   or different cycles, in either order. When both done -> BREADY=1 -> WR_RESP.
//  WR_RESP: BREADY=1; on BVALID capture BRESP -> RSP.
//  RSP: rsp_valid=1 held with stable rsp_* until rsp_ready; then IDLE (cmd_ready=1 following cycle).
//  No combinational path from any AXI input to any AXI output; all outputs registered.
//  VALID never deasserts before its handshake; payload never changes while VALID high.
//  READY outputs only asserted in the state expecting that channel; unexpected RVALID/BVALID ignored.
//  Exactly one outstanding transaction; cmd_ready=0 in every state except IDLE.
//  rsp_rdata zero for writes; RRESP/BRESP passed through unmodified (SLVERR/DECERR not retried).
//  Reset mid-transaction: all outputs return to reset values the following cycle; any in-flight
//   transaction is abandoned (system reset is common to master and slave).
// STRUCTURE
//  Shared package axi_lite_pkg: resp_t enum (OKAY=2'b00, EXOKAY=2'b01, SLVERR=2'b10, DECERR=2'b11),
//   master state enum typedef.
//  Single flat module; no sub-module (per-channel done flags aw_done/w_done live inside).
// TESTING
//  Read, slave ARREADY=1, RVALID 2 cycles later, RDATA=0xDEADBEEF -> rsp_rdata=0xDEADBEEF, rsp_resp=0, rsp_write=0.
//  Write addr 0x10 data 0xA5A5A5A5, AWREADY delayed 3 cycles, WREADY immediate -> WVALID drops first,
//   AWVALID held with AWADDR stable, BREADY only after both; rsp_write=1.
//  Write with WREADY before AWREADY, BRESP=2'b10 -> rsp_resp=2'b10, rsp_rdata=0.
//  rsp_ready held low 5 cycles -> rsp_valid/rsp_* stable, cmd_ready=0, no new ARVALID despite cmd_valid=1.
//  Back-to-back read then write with rsp_ready=1 -> second ARVALID/AWVALID exactly 2 cycles after rsp handshake.
//  reset asserted while in RD_DATA -> next cycle RREADY=0, ARVALID=0, rsp_valid=0, cmd_ready=0; IDLE after release.

Source files
------------

// File: rtl/axi_lite_pkg.sv
// Shared types for the AXI4-Lite master slice.
// Response codes and the master FSM state encoding.
package axi_lite_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic [2:0] {
    IDLE,
    RD_ADDR,
    RD_DATA,
    WR_REQ,
    WR_RESP,
    RSP
  } mst_state_t;

endpackage

// File: rtl/axi_lite_if.sv
// AXI4-Lite channel bundle (AR/R/AW/W/B).
// master drives requests, slave drives responses.
interface axi_lite_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);

  logic                    ARVALID;
  logic                    ARREADY;
  logic [ADDR_WIDTH-1:0]   ARADDR;
  logic                    RVALID;
  logic                    RREADY;
  logic [DATA_WIDTH-1:0]   RDATA;
  logic [1:0]              RRESP;
  logic                    AWVALID;
  logic                    AWREADY;
  logic [ADDR_WIDTH-1:0]   AWADDR;
  logic                    WVALID;
  logic                    WREADY;
  logic [DATA_WIDTH-1:0]   WDATA;
  logic [DATA_WIDTH/8-1:0] WSTRB;
  logic                    BVALID;
  logic                    BREADY;
  logic [1:0]              BRESP;

  modport master (
    output ARVALID, ARADDR, RREADY,
    output AWVALID, AWADDR,
    output WVALID, WDATA, WSTRB,
    output BREADY,
    input  ARREADY, RVALID, RDATA, RRESP,
    input  AWREADY, WREADY,
    input  BVALID, BRESP
  );

  modport slave (
    input  ARVALID, ARADDR, RREADY,
    input  AWVALID, AWADDR,
    input  WVALID, WDATA, WSTRB,
    input  BREADY,
    output ARREADY, RVALID, RDATA, RRESP,
    output AWREADY, WREADY,
    output BVALID, BRESP
  );

endinterface

// File: rtl/axi_lite_master.sv
// Single-outstanding AXI4-Lite initiator.
// One command in, one AXI transaction out, one response back.
module axi_lite_master
  import axi_lite_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  cmd_valid,
  output logic                  cmd_ready,
  input  logic                  cmd_write,
  input  logic [ADDR_WIDTH-1:0] cmd_addr,
  input  logic [DATA_WIDTH-1:0] cmd_wdata,
  output logic                  rsp_valid,
  input  logic                  rsp_ready,
  output logic                  rsp_write,
  output logic [DATA_WIDTH-1:0] rsp_rdata,
  output logic [1:0]            rsp_resp,
  axi_lite_if.master            axi
);

  mst_state_t state;
  logic       aw_done;
  logic       w_done;
  logic       aw_hs;
  logic       w_hs;
  logic       aw_fin;
  logic       w_fin;

  assign aw_hs  = axi.AWVALID & axi.AWREADY;
  assign w_hs   = axi.WVALID & axi.WREADY;
  assign aw_fin = aw_done | aw_hs;
  assign w_fin  = w_done | w_hs;

  assign axi.WSTRB = '1;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmd_ready   <= 1'b0;
      rsp_valid   <= 1'b0;
      rsp_write   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_resp    <= '0;
      aw_done     <= 1'b0;
      w_done      <= 1'b0;
      axi.ARVALID <= 1'b0;
      axi.ARADDR  <= '0;
      axi.RREADY  <= 1'b0;
      axi.AWVALID <= 1'b0;
      axi.AWADDR  <= '0;
      axi.WVALID  <= 1'b0;
      axi.WDATA   <= '0;
      axi.BREADY  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            cmd_ready <= 1'b0;
            if (cmd_write) begin
              axi.AWADDR  <= cmd_addr;
              axi.WDATA   <= cmd_wdata;
              axi.AWVALID <= 1'b1;
              axi.WVALID  <= 1'b1;
              aw_done     <= 1'b0;
              w_done      <= 1'b0;
              state       <= WR_REQ;
            end else begin
              axi.ARADDR  <= cmd_addr;
              axi.ARVALID <= 1'b1;
              state       <= RD_ADDR;
            end
          end else begin
            cmd_ready <= 1'b1;
          end
        end
        RD_ADDR: begin
          if (axi.ARREADY) begin
            axi.ARVALID <= 1'b0;
            axi.RREADY  <= 1'b1;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (axi.RVALID) begin
            axi.RREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= 1'b0;
            rsp_rdata  <= axi.RDATA;
            rsp_resp   <= axi.RRESP;
            state      <= RSP;
          end
        end
        WR_REQ: begin
          // AW and W retire independently; B opens once both are done
          if (aw_hs) begin
            axi.AWVALID <= 1'b0;
            aw_done     <= 1'b1;
          end
          if (w_hs) begin
            axi.WVALID <= 1'b0;
            w_done     <= 1'b1;
          end
          if (aw_fin && w_fin) begin
            axi.BREADY <= 1'b1;
            state      <= WR_RESP;
          end
        end
        WR_RESP: begin
          if (axi.BVALID) begin
            axi.BREADY <= 1'b0;
            rsp_valid  <= 1'b1;
            rsp_write  <= 1'b1;
            rsp_rdata  <= '0;
            rsp_resp   <= axi.BRESP;
            state      <= RSP;
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
